regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter feeding one register-file write port.
// Round-robin or fixed priority; zero-address writes are accepted and dropped.
module regfile_wb_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        we,
  output logic [4:0]  wAddr,
  output logic [31:0] wData,
  input  logic [4:0]  rd_addr,
  output logic        rd_pending,
  output logic [15:0] wr_cnt
);

  typedef enum logic {
    LAST_REQ0 = 1'b0,
    LAST_REQ1 = 1'b1
  } last_e;

  last_e       last_q, last_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  logic        grant0, grant1, xfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    // Grants are masked during reset so no transfer can occur on a reset edge.
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        if (FIXED_PRIO != 0 || last_q == LAST_REQ1) grant0 = 1'b1;
        else                                        grant1 = 1'b1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end

    xfer     = grant0 | grant1;
    sel_addr = grant1 ? req1_addr : req0_addr;
    sel_data = grant1 ? req1_data : req0_data;

    last_d = last_q;
    if (grant0) last_d = LAST_REQ0;
    if (grant1) last_d = LAST_REQ1;

    we_d     = xfer && (sel_addr != '0);
    waddr_d  = we_d ? sel_addr : waddr_q;
    wdata_d  = we_d ? sel_data : wdata_q;
    wr_cnt_d = wr_cnt_q + {15'd0, we_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= LAST_REQ1;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wr_cnt_q <= '0;
    end else begin
      last_q   <= last_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    rd_pending = 1'b0;
    if (rd_addr != '0) begin
      rd_pending = (req0_valid && (req0_addr == rd_addr)) ||
                   (req1_valid && (req1_addr == rd_addr)) ||
                   (we_q && (waddr_q == rd_addr));
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign we         = we_q;
  assign wAddr      = waddr_q;
  assign wData      = wdata_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench: round-robin instance checked from a table,
// fixed-priority instance and counter wrap checked by hand sequences.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [4:0]  a0 = '0, a1 = '0, rd = '0;
  logic [31:0] d0 = '0, d1 = '0;

  logic        r0_rr, r1_rr, we_rr, pend_rr;
  logic [4:0]  wa_rr;
  logic [31:0] wd_rr;
  logic [15:0] cnt_rr;
  logic        r0_fp, r1_fp, we_fp, pend_fp;
  logic [4:0]  wa_fp;
  logic [31:0] wd_fp;
  logic [15:0] cnt_fp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_rr),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_rr),
    .we(we_rr), .wAddr(wa_rr), .wData(wd_rr),
    .rd_addr(rd), .rd_pending(pend_rr), .wr_cnt(cnt_rr)
  );

  regfile_wb_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_fp),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_fp),
    .we(we_fp), .wAddr(wa_fp), .wData(wd_fp),
    .rd_addr(rd), .rd_pending(pend_fp), .wr_cnt(cnt_fp)
  );

  typedef struct {
    logic        rst, v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [4:0]  rd;
    logic        r0, r1, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [15:0] cnt;
    logic        pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic xrst, input logic xv0, input logic [4:0] xa0, input logic [31:0] xd0,
                     input logic xv1, input logic [4:0] xa1, input logic [31:0] xd1, input logic [4:0] xrd,
                     input logic er0, input logic er1, input logic ewe, input logic [4:0] ewa,
                     input logic [31:0] ewd, input logic [15:0] ecnt, input logic epend);
    vec_t v;
    v.rst = xrst; v.v0 = xv0; v.a0 = xa0; v.d0 = xd0; v.v1 = xv1; v.a1 = xa1; v.d1 = xd1; v.rd = xrd;
    v.r0 = er0; v.r1 = er1; v.we = ewe; v.wa = ewa; v.wd = ewd; v.cnt = ecnt; v.pend = epend;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic xv0, input logic [4:0] xa0, input logic [31:0] xd0,
                       input logic xv1, input logic [4:0] xa1, input logic [31:0] xd1, input logic [4:0] xrd);
    v0 = xv0; a0 = xa0; d0 = xd0; v1 = xv1; a1 = xa1; d1 = xd1; rd = xrd;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   rst   v0    a0     d0            v1    a1     d1            rd       r0    r1    we    wa     wd            cnt       pend
    add(1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,    1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        16'd0,    1'b0);
    add(1'b0, 1'b1, 5'd5,  32'h1234_5678,1'b0, 5'd0,  32'h0,        5'd5,    1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        16'd0,    1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,    1'b0, 1'b0, 1'b1, 5'd5,  32'h1234_5678,16'd0,    1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,    1'b0, 1'b0, 1'b0, 5'd5,  32'h1234_5678,16'd1,    1'b0);
    add(1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,    1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        16'd0,    1'b0);
    add(1'b0, 1'b1, 5'd1,  32'hA1,       1'b1, 5'd2,  32'hB2,       5'd2,    1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        16'd0,    1'b1);
    add(1'b0, 1'b1, 5'd1,  32'hA1,       1'b1, 5'd2,  32'hB2,       5'd2,    1'b0, 1'b1, 1'b1, 5'd1,  32'hA1,       16'd0,    1'b1);
    add(1'b0, 1'b1, 5'd1,  32'hA1,       1'b1, 5'd2,  32'hB2,       5'd2,    1'b1, 1'b0, 1'b1, 5'd2,  32'hB2,       16'd1,    1'b1);
    add(1'b0, 1'b1, 5'd1,  32'hA1,       1'b1, 5'd2,  32'hB2,       5'd2,    1'b0, 1'b1, 1'b1, 5'd1,  32'hA1,       16'd2,    1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,    1'b0, 1'b0, 1'b1, 5'd2,  32'hB2,       16'd3,    1'b0);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFF_FFFF,5'd0,    1'b0, 1'b1, 1'b0, 5'd2,  32'hB2,       16'd4,    1'b0);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd2,    1'b0, 1'b0, 1'b0, 5'd2,  32'hB2,       16'd4,    1'b0);
    add(1'b0, 1'b1, 5'd7,  32'h77,       1'b0, 5'd0,  32'h0,        5'd7,    1'b1, 1'b0, 1'b0, 5'd2,  32'hB2,       16'd4,    1'b1);
    add(1'b1, 1'b1, 5'd9,  32'h99,       1'b0, 5'd0,  32'h0,        5'd7,    1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        16'd0,    1'b0);
    add(1'b0, 1'b1, 5'd3,  32'h33,       1'b1, 5'd4,  32'h44,       5'd0,    1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        16'd0,    1'b0);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,    1'b0, 1'b0, 1'b1, 5'd3,  32'h33,       16'd0,    1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,    1'b0, 1'b0, 1'b0, 5'd3,  32'h33,       16'd1,    1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].rd);
      #1;
      chk($sformatf("v%0d.r0", i),   32'(r0_rr),   32'(vecs[i].r0));
      chk($sformatf("v%0d.r1", i),   32'(r1_rr),   32'(vecs[i].r1));
      chk($sformatf("v%0d.we", i),   32'(we_rr),   32'(vecs[i].we));
      chk($sformatf("v%0d.wa", i),   32'(wa_rr),   32'(vecs[i].wa));
      chk($sformatf("v%0d.wd", i),   wd_rr,        vecs[i].wd);
      chk($sformatf("v%0d.cnt", i),  32'(cnt_rr),  32'(vecs[i].cnt));
      chk($sformatf("v%0d.pend", i), 32'(pend_rr), 32'(vecs[i].pend));
    end

    // Fixed priority: requester 1 starves while requester 0 keeps asking.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5'd4, 32'h4444, 1'b1, 5'd19, 32'h1919, 5'd19);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("fp%0d.r0", k), 32'(r0_fp), 32'd1);
      chk($sformatf("fp%0d.r1", k), 32'(r1_fp), 32'd0);
      chk($sformatf("fp%0d.pend19", k), 32'(pend_fp), 32'd1);
      @(negedge clk);
    end
    rd = 5'd0;
    #1;
    chk("fp.pend0", 32'(pend_fp), 32'd0);
    chk("fp.we", 32'(we_fp), 32'd1);
    chk("fp.wa", 32'(wa_fp), 32'd4);
    chk("fp.cnt", 32'(cnt_fp), 32'd2);
    @(negedge clk);
    v0 = 1'b0;
    #1;
    chk("fp.r1_after_drop", 32'(r1_fp), 32'd1);
    chk("fp.r0_after_drop", 32'(r0_fp), 32'd0);
    @(negedge clk);
    v1 = 1'b0;
    #1;
    chk("fp.wa19", 32'(wa_fp), 32'd19);
    chk("fp.wd19", wd_fp, 32'h1919);

    // Back-to-back traffic through the counter wrap.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5'd1, 32'hC0DE, 1'b0, 5'd0, 32'h0, 5'd0);
    repeat (65536) @(negedge clk);
    #1;
    chk("wrap.cnt_ffff", 32'(cnt_rr), 32'h0000_FFFF);
    chk("wrap.we_busy", 32'(we_rr), 32'd1);
    v0 = 1'b0;
    @(negedge clk);
    #1;
    chk("wrap.cnt_0", 32'(cnt_rr), 32'd0);
    chk("wrap.we_idle", 32'(we_rr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
